// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode queue: instruction width and the packed {pc, instr} entry width.
`ifndef QUEUE_ENTRY_W
`define QUEUE_ENTRY_W (32+PC_WIDTH)
`endif

package decode_queue_pkg;
  localparam int unsigned INSTR_W = 32;
endpackage

// File: rtl/lead_ones_cnt.sv
// Counts consecutive ones in vec starting from bit 0 (4'b1101 -> 1).
module lead_ones_cnt #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              vec,
  output logic [$clog2(N+1)-1:0]    cnt
);
  localparam int unsigned CW = $clog2(N+1);

  logic hit_zero;

  always_comb begin
    cnt      = '0;
    hit_zero = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!hit_zero) begin
        if (vec[i]) cnt = CW'(i + 1);
        else        hit_zero = 1'b1;
      end
    end
  end
endmodule

// File: rtl/decode_queue.sv
// In-order instruction buffer between fetch and the decoder: prefix enqueue,
// all-or-nothing dequeue of up to DECODE_NUM oldest entries, flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DECODE_NUM = 4,
  parameter int unsigned FETCH_NUM  = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [FETCH_NUM-1:0]                  fetch_valid,
  input  logic [FETCH_NUM-1:0][INSTR_W-1:0]     fetch_instr,
  input  logic [FETCH_NUM-1:0][PC_WIDTH-1:0]    fetch_pc,
  output logic                                  fetch_ready,
  output logic [DECODE_NUM-1:0]                 dec_valid,
  output logic [DECODE_NUM-1:0][INSTR_W-1:0]    dec_instr,
  output logic [DECODE_NUM-1:0][PC_WIDTH-1:0]   dec_pc,
  input  logic                                  dec_ready,
  output logic [CNT_W-1:0]                      count
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = `QUEUE_ENTRY_W;
  localparam int unsigned IN_W    = $clog2(FETCH_NUM + 1);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [IN_W-1:0]    n_in;
  logic [IN_W-1:0]    n_acc;
  logic [CNT_W-1:0]   n_out;

  lead_ones_cnt #(.N(FETCH_NUM)) u_lead_ones (
    .vec (fetch_valid),
    .cnt (n_in)
  );

  // Room for a whole fetch group; based on registered count only.
  always_comb fetch_ready = (count <= CNT_W'(DEPTH - FETCH_NUM));
  always_comb n_acc = fetch_ready ? n_in : '0;

  always_comb begin
    n_out = '0;
    if (dec_ready) n_out = (count >= CNT_W'(DECODE_NUM)) ? CNT_W'(DECODE_NUM) : count;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(n_out);
      wr_ptr <= wr_ptr + PTR_W'(n_acc);
      count  <= count + CNT_W'(n_acc) - n_out;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < int'(FETCH_NUM); k++) begin
        if (IN_W'(k) < n_acc) mem[wr_ptr + PTR_W'(k)] <= {fetch_pc[k], fetch_instr[k]};
      end
    end
  end

  always_comb begin
    dec_valid = '0;
    dec_instr = '0;
    dec_pc    = '0;
    for (int i = 0; i < int'(DECODE_NUM); i++) begin
      if (count > CNT_W'(i)) begin
        dec_valid[i]              = 1'b1;
        {dec_pc[i], dec_instr[i]} = mem[rd_ptr + PTR_W'(i)];
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus randomized traffic against a queue model.
module tb_decode_queue;
  localparam int DN = 4;
  localparam int FN = 4;
  localparam int DEPTH = 16;
  localparam int PCW = 64;
  localparam int CW = 5;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [31:0]    instr;
  } ent_t;

  logic                    clk = 1'b0;
  logic                    rst, flush, dec_ready, fetch_ready;
  logic [FN-1:0]           fetch_valid;
  logic [FN-1:0][31:0]     fetch_instr;
  logic [FN-1:0][PCW-1:0]  fetch_pc;
  logic [DN-1:0]           dec_valid;
  logic [DN-1:0][31:0]     dec_instr;
  logic [DN-1:0][PCW-1:0]  dec_pc;
  logic [CW-1:0]           count;

  int checks = 0;
  int errors = 0;
  ent_t mq[$];

  decode_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [PCW-1:0] pc);
    return pc[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Present a group of 4 consecutive PCs starting at base with the given valid mask.
  task automatic offer(input logic [FN-1:0] v, input logic [PCW-1:0] base);
    fetch_valid = v;
    for (int k = 0; k < FN; k++) begin
      fetch_pc[k]    = base + PCW'(4 * k);
      fetch_instr[k] = instr_of(fetch_pc[k]);
    end
  endtask

  // One clock edge; the model consumes the inputs sampled at that edge.
  task automatic tick();
    int nin, nout;
    bit room;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      room = (DEPTH - mq.size()) >= FN;
      nin = 0;
      while (nin < FN && fetch_valid[nin]) nin++;
      nout = dec_ready ? ((mq.size() < DN) ? mq.size() : DN) : 0;
      for (int i = 0; i < nout; i++) void'(mq.pop_front());
      if (room) for (int k = 0; k < nin; k++) mq.push_back('{fetch_pc[k], fetch_instr[k]});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0; offer('0, '0);
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (dec_valid !== 4'b0000) begin errors++; $display("FAIL reset_dec_valid got %b exp 0000", dec_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready got %b exp 1", fetch_ready); end
    checks++; if (dec_instr !== '0 || dec_pc !== '0) begin errors++; $display("FAIL reset_dec_data got instr %h pc %h exp 0", dec_instr, dec_pc); end
  endtask

  task automatic test_single_group();
    offer(4'b1111, 64'h1000); dec_ready = 1'b0;
    tick();
    offer('0, '0);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL single_count got %0d exp 4", count); end
    checks++; if (dec_valid !== 4'b1111) begin errors++; $display("FAIL single_valid got %b exp 1111", dec_valid); end
    for (int i = 0; i < DN; i++) begin
      checks++;
      if (dec_pc[i] !== PCW'(64'h1000 + 4 * i) || dec_instr[i] !== instr_of(PCW'(64'h1000 + 4 * i))) begin
        errors++; $display("FAIL single_slot%0d got pc %h instr %h exp pc %h", i, dec_pc[i], dec_instr[i], 64'h1000 + 4 * i);
      end
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", count); end
  endtask

  task automatic test_partial_prefix();
    offer(4'b0011, 64'h2000); tick();
    offer(4'b0111, 64'h2008); tick();
    offer('0, '0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL prefix_count got %0d exp 5", count); end
    checks++; if (dec_valid !== 4'b1111) begin errors++; $display("FAIL prefix_valid got %b exp 1111", dec_valid); end
    for (int i = 0; i < DN; i++) begin
      checks++;
      if (dec_pc[i] !== PCW'(64'h2000 + 4 * i)) begin errors++; $display("FAIL prefix_slot%0d got %h exp %h", i, dec_pc[i], 64'h2000 + 4 * i); end
    end
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    checks++; if (count !== 5'd1 || dec_valid !== 4'b0001) begin errors++; $display("FAIL prefix_after_deq got count %0d valid %b exp 1 0001", count, dec_valid); end
    checks++; if (dec_pc[0] !== 64'h2010) begin errors++; $display("FAIL prefix_fifth_pc got %h exp 2010", dec_pc[0]); end
    offer(4'b1101, 64'h3000); tick(); offer('0, '0);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL prefix_1101 got %0d exp 2", count); end
    checks++; if (dec_pc[1] !== 64'h3000 || dec_valid !== 4'b0011) begin errors++; $display("FAIL prefix_1101_slot got %h valid %b exp 3000 0011", dec_pc[1], dec_valid); end
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    dec_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_g%0d got %b exp 1", g, fetch_ready); end
      offer(4'b1111, PCW'(64'h4000 + 16 * g)); tick();
    end
    checks++; if (count !== 5'd16 || fetch_ready !== 1'b0 || dec_valid !== 4'b1111) begin
      errors++; $display("FAIL fill_full got count %0d ready %b valid %b exp 16 0 1111", count, fetch_ready, dec_valid);
    end
    offer(4'b1111, 64'h4040); tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_ignored got %0d exp 16", count); end
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    checks++; if (count !== 5'd12) begin errors++; $display("FAIL fill_full_deq got %0d exp 12", count); end
    tick(); offer('0, '0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_accept_held got %0d exp 16", count); end
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < DN; i++) begin
        checks++;
        if (dec_pc[i] !== PCW'(64'h4010 + 16 * g + 4 * i)) begin
          errors++; $display("FAIL fill_order_g%0d_s%0d got %h exp %h", g, i, dec_pc[i], 64'h4010 + 16 * g + 4 * i);
        end
      end
      dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_drained got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [PCW-1:0] exp_pc = 64'h5000;
    dec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      offer(4'b1111, PCW'(64'h5000 + 16 * c)); tick();
      checks++; if (count !== 5'd4) begin errors++; $display("FAIL b2b_count_c%0d got %0d exp 4", c, count); end
      for (int i = 0; i < DN; i++) begin
        checks++;
        if (dec_pc[i] !== exp_pc) begin errors++; $display("FAIL b2b_pc_c%0d_s%0d got %h exp %h", c, i, dec_pc[i], exp_pc); end
        exp_pc += 4;
      end
    end
    offer('0, '0); tick(); dec_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    offer(4'b1111, 64'h6100); tick();
    offer(4'b0111, 64'h6110); tick();
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL flush_pre got %0d exp 7", count); end
    flush = 1'b1; dec_ready = 1'b1; offer(4'b1111, 64'h6200); tick();
    flush = 1'b0; dec_ready = 1'b0; offer('0, '0);
    checks++; if (count !== 5'd0 || dec_valid !== 4'b0000 || fetch_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got count %0d valid %b ready %b exp 0 0000 1", count, dec_valid, fetch_ready);
    end
    offer(4'b0001, 64'h6000); tick(); offer('0, '0);
    checks++; if (dec_valid !== 4'b0001 || dec_pc[0] !== 64'h6000 || count !== 5'd1) begin
      errors++; $display("FAIL flush_refill got valid %b pc %h count %0d exp 0001 6000 1", dec_valid, dec_pc[0], count);
    end
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
  endtask

  task automatic test_random();
    ent_t e;
    for (int c = 0; c < 400; c++) begin
      fetch_valid = 4'($urandom);
      for (int k = 0; k < FN; k++) begin
        fetch_pc[k]    = {32'($urandom), 32'($urandom)};
        fetch_instr[k] = 32'($urandom);
      end
      dec_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      checks++;
      if (count !== CW'(mq.size()) || fetch_ready !== ((DEPTH - mq.size()) >= FN)) begin
        errors++; $display("FAIL rand_c%0d_state got count %0d ready %b exp count %0d", c, count, fetch_ready, mq.size());
      end
      for (int i = 0; i < DN; i++) begin
        checks++;
        if (i < mq.size()) begin
          e = mq[i];
          if (dec_valid[i] !== 1'b1 || dec_pc[i] !== e.pc || dec_instr[i] !== e.instr) begin
            errors++; $display("FAIL rand_c%0d_s%0d got v %b pc %h instr %h exp v 1 pc %h instr %h", c, i, dec_valid[i], dec_pc[i], dec_instr[i], e.pc, e.instr);
          end
        end else if (dec_valid[i] !== 1'b0 || dec_pc[i] !== '0 || dec_instr[i] !== '0) begin
          errors++; $display("FAIL rand_c%0d_s%0d got v %b pc %h instr %h exp all 0", c, i, dec_valid[i], dec_pc[i], dec_instr[i]);
        end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; dec_ready = 1'b0; offer('0, '0);
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_partial_prefix();
    test_fill_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
